// File: rtl/dmem_arbiter.sv
// Purpose: shares one single-port synchronous data RAM between the CPU MEM stage (c_) and the UART loader (u_).
// Latency: counted from the cycle a request is seen in IDLE, a write completes in cycle 2 and a read in cycle 3.
// Backpressure: one access in flight; a waiting requester holds its request until its done pulse (c_stall for CPU).
//
// Parameters : ADDR_W RAM word-address width (depth 2**ADDR_W), DATA_W data width.
// Ports      : clk, rst (async, active-high)
//              c_req/c_we/c_addr/c_wdata -> c_rdata/c_done/c_stall   CPU side
//              u_req/u_we/u_addr/u_wdata -> u_rdata/u_done           loader side
//              err                    pulses with done when the granted address is out of range
//              ram_addr/ram_din/ram_we -> RAM, ram_dout <- RAM (one-cycle read latency)
// Build opt  : define DMEM_ARB_RR_EN for round-robin tie-breaking; by default the loader has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [31:0]       c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_done,
  output logic              c_stall,
  input  logic              u_req,
  input  logic              u_we,
  input  logic [31:0]       u_addr,
  input  logic [DATA_W-1:0] u_wdata,
  output logic [DATA_W-1:0] u_rdata,
  output logic              u_done,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  state_t state, stateNext;

  // Captured transaction; owner 0 = CPU, 1 = loader.
  logic              owner;
  logic              weR;
  logic              inRangeR;
  logic [ADDR_W-1:0] addrR;
  logic [DATA_W-1:0] wdataR;

  logic              anyReq;
  logic              grantNow;
  logic              grantLdr;
  logic              selWe;
  logic              selInRange;
  logic [31:0]       selAddr;
  logic [DATA_W-1:0] selWdata;
  logic              doneNow;
  logic [DATA_W-1:0] rdataNow;

  assign anyReq   = c_req | u_req;
  assign grantNow = (state == IDLE) & anyReq;

`ifdef DMEM_ARB_RR_EN
  // rrPtr names the port favoured on a tie; after each grant it points at the port that lost.
  logic rrPtr;

  always_comb begin
    grantLdr = u_req;
    if (c_req && u_req) grantLdr = rrPtr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr <= 1'b0;
    end else if (grantNow) begin
      rrPtr <= ~grantLdr;
    end
  end
`else
  // Loader wins whenever it asks; a lone CPU request is still granted.
  assign grantLdr = u_req;
`endif

  assign selWe    = grantLdr ? u_we    : c_we;
  assign selAddr  = grantLdr ? u_addr  : c_addr;
  assign selWdata = grantLdr ? u_wdata : c_wdata;

  // Anything above the RAM's byte range is out of range; byte-offset bits [1:0] carry no meaning.
  assign selInRange = ((selAddr >> (ADDR_W + 2)) == 32'd0);

  logic unusedByteOffset;
  assign unusedByteOffset = ^selAddr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      weR      <= 1'b0;
      inRangeR <= 1'b0;
      addrR    <= '0;
      wdataR   <= '0;
    end else begin
      state <= stateNext;
      if (grantNow) begin
        owner    <= grantLdr;
        weR      <= selWe;
        inRangeR <= selInRange;
        addrR    <= selAddr[ADDR_W+1:2];
        wdataR   <= selWdata;
      end
    end
  end

  // ram_we is decoded from state so that an async reset drops it in the same cycle.
  always_comb begin
    stateNext = state;
    doneNow   = 1'b0;
    rdataNow  = '0;
    ram_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (anyReq) stateNext = ACCESS;
      end
      ACCESS: begin
        ram_we = weR & inRangeR;
        if (weR) begin
          doneNow   = 1'b1;
          stateNext = IDLE;
        end else begin
          stateNext = RDATA;
        end
      end
      RDATA: begin
        doneNow   = 1'b1;
        if (inRangeR) rdataNow = ram_dout;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // RAM address/data come straight from the capture registers, so they hold between accesses.
  assign ram_addr = addrR;
  assign ram_din  = wdataR;

  assign c_done  = doneNow & ~owner;
  assign u_done  = doneNow & owner;
  assign c_rdata = owner ? '0 : rdataNow;
  assign u_rdata = owner ? rdataNow : '0;
  assign err     = doneNow & ~inRangeR;
  assign c_stall = c_req & ~c_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: randomized and directed stimulus for dmem_arbiter, checked against a transaction-level model.
// Latency: the model grants on a free cycle and expects done 1 (write) or 2 (read) cycles later.
// Backpressure: each requester holds its request until the model says it completes, then may reissue.
module tb_dmem_arbiter;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              c_req, c_we, c_done, c_stall;
  logic              u_req, u_we, u_done;
  logic [31:0]       c_addr, u_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata, u_wdata, u_rdata;
  logic              err, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;

  // Requester drive; index 0 = CPU, 1 = loader.
  logic [1:0]  reqD, weD;
  logic [31:0] addrD [2];
  logic [31:0] wdataD [2];

  assign c_req   = reqD[0];
  assign c_we    = weD[0];
  assign c_addr  = addrD[0];
  assign c_wdata = wdataD[0];
  assign u_req   = reqD[1];
  assign u_we    = weD[1];
  assign u_addr  = addrD[1];
  assign u_wdata = wdataD[1];

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_done(c_done), .c_stall(c_stall),
    .u_req(u_req), .u_we(u_we), .u_addr(u_addr), .u_wdata(u_wdata),
    .u_rdata(u_rdata), .u_done(u_done),
    .err(err), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  function automatic logic [31:0] initWord(input int k);
    return 32'h5A00_0000 ^ (32'(k) * 32'h0001_0101);
  endfunction

  // Synchronous RAM, one-cycle read latency.
  logic              ramLoad;
  logic [DATA_W-1:0] ramMem [DEPTH];
  always @(posedge clk) begin
    if (ramLoad) begin
      for (int k = 0; k < DEPTH; k++) ramMem[k] <= initWord(k);
    end else begin
      if (ram_we) ramMem[ram_addr] <= ram_din;
      ram_dout <= ramMem[ram_addr];
    end
  end

  // Protocol guard on the bench's own drivers: request fields stay put until done.
  logic        cPend, uPend, cWePrev, uWePrev;
  logic [31:0] cAddrPrev, uAddrPrev;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cPend <= 1'b0;
      uPend <= 1'b0;
    end else begin
      if (cPend) assert (c_req && c_we == cWePrev && c_addr == cAddrPrev)
        else $error("FAIL proto_c: request changed before c_done");
      if (uPend) assert (u_req && u_we == uWePrev && u_addr == uAddrPrev)
        else $error("FAIL proto_u: request changed before u_done");
      cPend <= c_req & ~c_done;  cWePrev <= c_we;  cAddrPrev <= c_addr;
      uPend <= u_req & ~u_done;  uWePrev <= u_we;  uAddrPrev <= u_addr;
    end
  end

  int cyc = 0;
  int nCompared = 0;
  int nMismatched = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: observed %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
  } txn_t;
  txn_t txq[$];

  task automatic pushTxn(input int port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gap);
    txn_t t;
    t.port = port; t.we = we; t.addr = addr; t.wdata = wdata; t.gap = gap;
    txq.push_back(t);
  endtask

  // Reference model: memory contents plus, per port, the transaction in progress.
  logic [31:0] refMem [DEPTH];
  bit          active [2];
  bit          granted [2];
  bit          curWe [2];
  bit          inRng [2];
  int          doneAt [2];
  int          curGap [2];
  int          gapCnt [2];
  logic [31:0] curAddr [2];
  logic [31:0] expRd [2];
  int          freeAt = 0;
  bit          rrFav = 1'b0;
  int          accAt = -1;
  bit          accWrite;
  logic [13:0] accWord;
  logic [31:0] accData;

  task automatic popTxn(input int p);
    for (int k = 0; k < txq.size(); k++) begin
      if (txq[k].port == p) begin
        curWe[p]   = txq[k].we;
        curAddr[p] = txq[k].addr;
        curGap[p]  = txq[k].gap;
        active[p]  = 1'b1;
        granted[p] = 1'b0;
        weD[p]     = txq[k].we;
        addrD[p]   = txq[k].addr;
        wdataD[p]  = txq[k].wdata;
        txq.delete(k);
        return;
      end
    end
  endtask

  task automatic runPeriod();
    bit   w0, w1, tie;
    int   win;
    int   word;
    logic [1:0] expDone;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (active[i] && granted[i] && doneAt[i] == cyc - 1) begin
        active[i] = 1'b0;
        gapCnt[i] = curGap[i];
      end
      if (!active[i]) begin
        if (gapCnt[i] > 0) gapCnt[i]--;
        else popTxn(i);
      end
      reqD[i] = active[i];
    end
    // The RAM is free in this cycle: award it to one waiting port.
    if (cyc >= freeAt) begin
      w0 = active[0] && !granted[0];
      w1 = active[1] && !granted[1];
      tie = w0 && w1;
      if (w0 || w1) begin
`ifdef DMEM_ARB_RR_EN
        win = tie ? int'(rrFav) : (w1 ? 1 : 0);
        rrFav = (win == 0);
`else
        win = (w1 || tie) ? 1 : 0;
`endif
        granted[win] = 1'b1;
        doneAt[win]  = cyc + (curWe[win] ? 1 : 2);
        freeAt       = doneAt[win] + 1;
        inRng[win]   = (curAddr[win][31:16] == 16'd0);
        word         = int'(curAddr[win][15:2]);
        accAt        = cyc + 1;
        accWord      = curAddr[win][15:2];
        accData      = wdataD[win];
        accWrite     = curWe[win] && inRng[win];
        expRd[win]   = 32'd0;
        if (inRng[win]) begin
          if (curWe[win]) refMem[word] = wdataD[win];
          else expRd[win] = refMem[word];
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) expDone[i] = active[i] && granted[i] && doneAt[i] == cyc;
    checkVal("c_done", c_done, expDone[0]);
    checkVal("u_done", u_done, expDone[1]);
    checkVal("c_stall", c_stall, reqD[0] && !expDone[0]);
    checkVal("err", err, (expDone[0] && !inRng[0]) || (expDone[1] && !inRng[1]));
    if (!(expDone[0] && curWe[0])) checkVal("c_rdata", c_rdata, expDone[0] ? expRd[0] : 32'd0);
    if (!(expDone[1] && curWe[1])) checkVal("u_rdata", u_rdata, expDone[1] ? expRd[1] : 32'd0);
    checkVal("ram_we", ram_we, (cyc == accAt) && accWrite);
    if (cyc == accAt) begin
      checkVal("ram_addr", ram_addr, accWord);
      if (accWrite) checkVal("ram_din", ram_din, accData);
    end
  endtask

  task automatic runUntilIdle(input int budget);
    int n = 0;
    while ((txq.size() != 0 || active[0] || active[1]) && n < budget) begin
      runPeriod();
      n++;
    end
    checkVal("idle_budget", txq.size() == 0 && !active[0] && !active[1], 1'b1);
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 9) == 0) a = a | (32'($urandom_range(1, 65535)) << 16);
    return a;
  endfunction

  initial begin
    rst = 1'b1;
    ramLoad = 1'b1;
    reqD = '0;
    weD = '0;
    for (int i = 0; i < 2; i++) begin
      addrD[i] = '0; wdataD[i] = '0;
      active[i] = 1'b0; granted[i] = 1'b0; gapCnt[i] = 0; curGap[i] = 0;
      curWe[i] = 1'b0; inRng[i] = 1'b1; doneAt[i] = -1; expRd[i] = '0; curAddr[i] = '0;
    end
    for (int k = 0; k < DEPTH; k++) refMem[k] = initWord(k);
    repeat (2) @(posedge clk);
    #1 ramLoad = 1'b0;
    @(negedge clk);
    checkVal("rst_c_done", c_done, 1'b0);
    checkVal("rst_u_done", u_done, 1'b0);
    checkVal("rst_err", err, 1'b0);
    checkVal("rst_ram_we", ram_we, 1'b0);
    checkVal("rst_ram_addr", ram_addr, 32'd0);
    checkVal("rst_ram_din", ram_din, 32'd0);
    checkVal("rst_c_rdata", c_rdata, 32'd0);
    checkVal("rst_u_rdata", u_rdata, 32'd0);
    rst = 1'b0;

    // Simultaneous reads straight after reset: tie-break decides who goes first.
    pushTxn(0, 1'b0, 32'h0, 32'h0, 0);
    pushTxn(1, 1'b0, 32'h4, 32'h0, 0);
    runUntilIdle(20);

    // CPU write then read of the same word.
    pushTxn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    pushTxn(0, 1'b0, 32'h10, 32'h0, 0);
    runUntilIdle(20);
    checkVal("t1_word4", ramMem[4], 32'hDEADBEEF);

    // Out-of-range write/read, then word 0 must be untouched.
    pushTxn(0, 1'b1, 32'h0010_0000, 32'hCAFEF00D, 0);
    pushTxn(0, 1'b0, 32'h0010_0000, 32'h0, 0);
    pushTxn(0, 1'b0, 32'h0, 32'h0, 0);
    runUntilIdle(20);
    checkVal("oor_word0", ramMem[0], initWord(0));

    // Loader streams 16 writes while the CPU keeps reading word 2.
    for (int k = 0; k < 16; k++) pushTxn(1, 1'b1, 32'(k * 4), $urandom, 0);
    for (int k = 0; k < 3; k++) pushTxn(0, 1'b0, 32'h8, 32'h0, 0);
    runUntilIdle(200);

    // Byte-offset bits ignored.
    pushTxn(1, 1'b0, 32'h13, 32'h0, 0);
    runUntilIdle(20);

    // Random mix on both ports over a small shared window.
    for (int k = 0; k < 250; k++) begin
      pushTxn(0, 1'($urandom_range(0, 1)), randAddr(), $urandom, $urandom_range(0, 3));
      pushTxn(1, 1'($urandom_range(0, 1)), randAddr(), $urandom, $urandom_range(0, 3));
    end
    runUntilIdle(5000);

    // Reset in the middle of a write access.
    @(posedge clk);
    #1;
    cyc++;
    reqD[0] = 1'b1; weD[0] = 1'b1; addrD[0] = 32'h20; wdataD[0] = 32'h1234;
    @(negedge clk);
    checkVal("rst_idle_done", c_done, 1'b0);
    @(posedge clk);
    #1;
    cyc++;
    checkVal("rst_access_we", ram_we, 1'b1);
    rst = 1'b1;
    #1;
    checkVal("rst_we_drop", ram_we, 1'b0);
    checkVal("rst_no_done", c_done, 1'b0);
    reqD[0] = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      active[i] = 1'b0; granted[i] = 1'b0; gapCnt[i] = 0;
    end
    freeAt = 0;
    accAt = -1;
    rrFav = 1'b0;
    checkVal("rst_word8", ramMem[8], refMem[8]);
    pushTxn(0, 1'b0, 32'h20, 32'h0, 0);
    pushTxn(1, 1'b1, 32'h24, 32'h0BAD_F00D, 1);
    pushTxn(1, 1'b0, 32'h24, 32'h0, 0);
    runUntilIdle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
